exu_lsu: RTL and testbench
==========================

// Module: exu_lsu
// PURPOSE
//  Load/store unit of the execute stage. Takes an effective address (ALU result) and store data (src2).
//  Runs a valid/ready transaction on the data-memory port and returns the load result, already
//  aligned and extended, on mem_r. The downstream writeback mux consumes mem_r.
//  Stalls the core until the access completes; one access in flight at a time.
// PARAMETERS
//  ISA_WIDTH   32   datapath width; only 32 is supported
//  MAX_WAIT    255  response cycles before timeout error; counter width = clog2(MAX_WAIT+1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous, active-low reset
//  req_valid       in   1   exu requests an access this cycle
//  req_ready       out  1   lsu can accept a request (IDLE state)
//  req_store       in   1   1=store, 0=load
//  req_size        in   2   0=byte, 1=half, 2=word; 3=illegal
//  req_unsigned    in   1   loads: 1=zero-extend, 0=sign-extend
//  addr            in   32  effective byte address
//  wdata           in   32  store data, low bits significant
//  mem_r           out  32  aligned/extended load data, held until next accepted request
//  done            out  1   one-cycle pulse: access finished (ok or error)
//  err             out  1   valid with done: misaligned, illegal size or timeout
//  dmem_req_valid  out  1   bus request valid
//  dmem_req_ready  in   1   bus accepts request
//  dmem_addr       out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_wen        out  1   bus write
//  dmem_wdata      out  32  store data shifted into byte lanes
//  dmem_wmask      out  4   byte-lane write strobes (0 for loads)
//  dmem_resp_valid in   1   read data / write ack valid
//  dmem_resp_rdata in   32  read data word
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; mem_r=0, done=0, err=0, dmem_req_valid=0, dmem_wen=0,
//    dmem_wmask=0, wait counter=0. Reset mid-transaction abandons it; late dmem_resp_valid is ignored.
//  - FSM IDLE->REQ->WAIT->DONE->IDLE. req_ready=1 only in IDLE; accept on req_valid&req_ready.
//    Latch store, size, unsigned flag and addr[1:0] at accept.
//  - Accept check: size==3, half with addr[0]!=0, or word with addr[1:0]!=0 -> go to DONE with err=1.
//    No bus request is issued.
//  - REQ: dmem_req_valid=1 with all dmem_* stable until dmem_req_ready; then go to WAIT.
//    dmem_req_ready may already be high in the first REQ cycle.
//  - WAIT: count cycles; on dmem_resp_valid capture data and go to DONE.
//    If count reaches MAX_WAIT without response -> DONE with err=1.
//    Response in the same cycle as the limit is reached counts as success.
//  - DONE: done=1, err per above, for exactly one cycle; mem_r updated on entry to DONE (loads only,
//    error or store leaves mem_r unchanged); return to IDLE.
//  - Minimum latency, zero-wait bus: accept@T, req handshake@T+1, resp@T+2, done@T+3.
//  - Store lanes: byte -> wdata[7:0] replicated, wmask=4'b0001<<addr[1:0];
//    half -> wdata[15:0] replicated, wmask=4'b0011<<addr[1:0]; word -> wmask=4'hF.
//  - Load extract: shift rdata right by 8*addr[1:0], then sign-/zero-extend byte or half to 32 bits.
// TESTING
//  1 lw addr=0x80000004, rdata=0xDEADBEEF, zero-wait -> done@T+3, mem_r=0xDEADBEEF, err=0
//  2 lbu addr=..03, rdata=0x80FF1234 -> mem_r=0x00000080; lb (signed) same -> mem_r=0xFFFFFF80
//  3 sh addr=..02, wdata=0x0000ABCD -> dmem_wdata=0xABCDABCD, wmask=4'b1100, wen=1, done after resp
//  4 sw addr=..01 -> done+err one cycle after accept, dmem_req_valid never asserted
//  5 dmem_req_ready low 3 cycles, resp delayed 5 -> request held stable, single done, no duplicate req
//  6 no response for MAX_WAIT cycles -> done+err; rst low while in WAIT -> IDLE, outputs 0, late resp ignored

Source files
------------

// File: rtl/exu_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : exu_lsu
//  Purpose  : Execute-stage load/store unit. Accepts one access at a time,
//             runs a valid/ready request on the data-memory port, waits for
//             the response and returns aligned, extended load data on mem_r.
//             Misaligned or illegal-size requests complete with err and never
//             reach the bus; a missing response is cut off after MAX_WAIT
//             cycles and also completes with err.
//  Ports    : clk, rst (sync, active-low)
//             req_*  / addr / wdata      : request from the execute stage
//             mem_r / done / err         : result, one-cycle done pulse
//             dmem_req_* / dmem_addr / dmem_wen / dmem_wdata / dmem_wmask
//                                        : bus request channel
//             dmem_resp_valid / dmem_resp_rdata : bus response channel
//  Revision : 1.0  initial release
// ============================================================================
module exu_lsu #(
    parameter int ISA_WIDTH = 32,   // only 32 is supported
    parameter int MAX_WAIT  = 255   // response cycles before timeout
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ISA_WIDTH-1:0] addr,
    input  logic [ISA_WIDTH-1:0] wdata,
    output logic [ISA_WIDTH-1:0] mem_r,
    output logic                 done,
    output logic                 err,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic [ISA_WIDTH-1:0] dmem_addr,
    output logic                 dmem_wen,
    output logic [ISA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]           dmem_wmask,
    input  logic                 dmem_resp_valid,
    input  logic [ISA_WIDTH-1:0] dmem_resp_rdata
);

    localparam int               c_cnt_w     = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MAX_WAIT - 1);
    localparam logic [1:0]       c_size_byte = 2'd0;
    localparam logic [1:0]       c_size_half = 2'd1;
    localparam logic [1:0]       c_size_word = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_store;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [1:0]             r_off;
    logic                   r_err;
    logic [c_cnt_w-1:0]     r_wait;
    logic [ISA_WIDTH-1:0]   r_mem_r;
    logic [ISA_WIDTH-1:0]   r_addr;
    logic                   r_wen;
    logic [ISA_WIDTH-1:0]   r_wdata;
    logic [3:0]             r_wmask;

    logic                   w_accept;
    logic                   w_bad;
    logic                   w_capture;
    logic                   w_timeout;
    logic [ISA_WIDTH-1:0]   w_lane_wdata;
    logic [3:0]             w_lane_wmask;
    logic [ISA_WIDTH-1:0]   w_shift;
    logic [ISA_WIDTH-1:0]   w_load;

    // Illegal size or an address not naturally aligned to the access size.
    always_comb begin
        w_bad = 1'b0;
        case (req_size)
            c_size_byte: w_bad = 1'b0;
            c_size_half: w_bad = addr[0];
            c_size_word: w_bad = |addr[1:0];
            default:     w_bad = 1'b1;
        endcase
    end

    // Store data is replicated across all lanes; the mask selects the lanes
    // actually written, so the bus never has to shift again.
    always_comb begin
        w_lane_wdata = wdata;
        w_lane_wmask = 4'hF;
        case (req_size)
            c_size_byte: begin
                w_lane_wdata = {4{wdata[7:0]}};
                w_lane_wmask = 4'b0001 << addr[1:0];
            end
            c_size_half: begin
                w_lane_wdata = {2{wdata[15:0]}};
                w_lane_wmask = 4'b0011 << addr[1:0];
            end
            default: begin
                w_lane_wdata = wdata;
                w_lane_wmask = 4'hF;
            end
        endcase
    end

    // Word accesses are aligned, so r_off is 0 and the shift is a pass-through.
    assign w_shift = dmem_resp_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_size)
            c_size_byte: w_load = r_unsigned ? {{(ISA_WIDTH-8){1'b0}}, w_shift[7:0]}
                                             : {{(ISA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            c_size_half: w_load = r_unsigned ? {{(ISA_WIDTH-16){1'b0}}, w_shift[15:0]}
                                             : {{(ISA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            default:     w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        dmem_req_valid = 1'b0;
        done           = 1'b0;
        w_capture      = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_bad ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle still wins.
                if (dmem_resp_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (r_wait == c_wait_last) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_store    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= 2'd0;
            r_err      <= 1'b0;
            r_wait     <= '0;
            r_mem_r    <= '0;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= 4'h0;
        end else begin
            if (w_accept) begin
                r_store    <= req_store;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_off      <= addr[1:0];
                r_err      <= w_bad;
                r_wait     <= '0;
            end
            // Bus fields only change for requests that will reach the bus.
            if (w_accept && !w_bad) begin
                r_addr  <= {addr[ISA_WIDTH-1:2], 2'b00};
                r_wen   <= req_store;
                r_wdata <= w_lane_wdata;
                r_wmask <= req_store ? w_lane_wmask : 4'h0;
            end
            if (r_state == S_WAIT) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_capture && !r_store) begin
                r_mem_r <= w_load;
            end
        end
    end

    assign err        = done & r_err;
    assign mem_r      = r_mem_r;
    assign dmem_addr  = r_addr;
    assign dmem_wen   = r_wen;
    assign dmem_wdata = r_wdata;
    assign dmem_wmask = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_exu_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exu_lsu
//  Purpose  : Self-checking bench for exu_lsu. Directed scenarios plus a
//             randomized sweep compared against a byte-lane reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exu_lsu;

    localparam int MW = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_r;
    logic        done;
    logic        err;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_resp_rdata = '0;

    exu_lsu #(.ISA_WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
        .mem_r(mem_r), .done(done), .err(err),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model_memr = '0;

    // observations from the last transaction
    int          ob_lat, ob_hs_lat, ob_hs_cnt, ob_extra;
    bit          ob_req_seen, ob_unstable;
    logic        ob_err, ob_rdy_after, ob_wen;
    logic [31:0] ob_memr, ob_addr, ob_wdata;
    logic [3:0]  ob_wmask;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd3) || ((int'(off) % nbytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic un);
        int nb;
        int x;
        logic [31:0] v;
        nb = nbytes(sz);
        v  = rd >> (8 * int'(off));
        if (nb == 4) return v;
        x = (nb == 1) ? int'(v[7:0]) : int'(v[15:0]);
        if (!un && x >= (1 << (8 * nb - 1))) x -= (1 << (8 * nb));
        return 32'(x);
    endfunction

    function automatic logic [3:0] ref_wmask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        m = 4'h0;
        for (int i = int'(off); i < int'(off) + nbytes(sz); i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    // ---------------- transaction driver / monitor ----------------
    // rdy_dly: cycles dmem_req_ready is held low once the request is seen.
    // resp_k : WAIT cycle (1-based) carrying the response; 0 = never.
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int rdy_dly, input int resp_k);
        int t_acc, hs_edge, stall;
        bit hs, fin;
        ob_lat = -1; ob_hs_lat = -1; ob_hs_cnt = 0; ob_extra = 0;
        ob_req_seen = 0; ob_unstable = 0; ob_err = 1'bx; ob_memr = 'x;
        ob_addr = 'x; ob_wen = 1'bx; ob_wdata = 'x; ob_wmask = 'x; ob_rdy_after = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        addr = a; wdata = wd;
        @(negedge clk);
        t_acc = cyc;
        req_valid = 1'b0; req_store = $urandom; req_size = 2'($urandom);
        req_unsigned = $urandom; addr = $urandom; wdata = $urandom;
        stall = 0; hs = 0; fin = 0; hs_edge = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = $urandom;
            if (dmem_req_valid) begin
                if (!ob_req_seen) begin
                    ob_addr = dmem_addr; ob_wen = dmem_wen;
                    ob_wdata = dmem_wdata; ob_wmask = dmem_wmask;
                end else if (dmem_addr !== ob_addr || dmem_wen !== ob_wen ||
                             dmem_wdata !== ob_wdata || dmem_wmask !== ob_wmask) begin
                    ob_unstable = 1;
                end
                ob_req_seen = 1;
                if (stall >= rdy_dly) begin
                    dmem_req_ready = 1'b1;
                    ob_hs_cnt++;
                    hs = 1;
                    hs_edge = cyc + 1;
                    ob_hs_lat = hs_edge - t_acc;
                end else begin
                    stall++;
                end
            end else if (hs && resp_k != 0 && (cyc - hs_edge + 1) == resp_k) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = rd;
            end
            if (done) begin
                ob_lat = cyc + 1 - t_acc;
                ob_err = err;
                ob_memr = mem_r;
                fin = 1;
            end
            @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
            if (done) ob_extra++;
            if (dmem_req_valid) ob_extra++;
            if (j == 0) ob_rdy_after = req_ready;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({req_ready, done, err, dmem_req_valid, dmem_wen, dmem_wmask, mem_r} !== {1'b1, 40'h0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b done=%b err=%b rv=%b wen=%b mask=%h mem_r=%h want rdy=1 rest 0",
                     req_ready, done, err, dmem_req_valid, dmem_wen, dmem_wmask, mem_r);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw;
        run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1);
        model_memr = 32'hDEAD_BEEF;
        n_vec++;
        if (ob_lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", ob_lat); end
        n_vec++;
        if (ob_memr !== 32'hDEAD_BEEF || ob_err !== 1'b0) begin
            n_err++; $display("FAIL lw_data: got %h err=%b want deadbeef err=0", ob_memr, ob_err);
        end
        n_vec++;
        if (ob_addr !== 32'h8000_0004 || ob_wen !== 1'b0 || ob_wmask !== 4'h0) begin
            n_err++; $display("FAIL lw_bus: addr=%h wen=%b mask=%h want 80000004 0 0", ob_addr, ob_wen, ob_wmask);
        end
    endtask

    task automatic test_load_ext;
        run_txn(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 1);
        n_vec++;
        if (ob_memr !== 32'h0000_0080) begin n_err++; $display("FAIL lbu: got %h want 00000080", ob_memr); end
        run_txn(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 1);
        n_vec++;
        if (ob_memr !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb: got %h want ffffff80", ob_memr); end
        run_txn(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 1);
        n_vec++;
        if (ob_memr !== 32'hFFFF_80FF) begin n_err++; $display("FAIL lh: got %h want ffff80ff", ob_memr); end
        model_memr = 32'hFFFF_80FF;
    endtask

    task automatic test_store;
        run_txn(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'h1111_1111, 0, 2);
        n_vec++;
        if (ob_wdata !== 32'hABCD_ABCD || ob_wmask !== 4'b1100 || ob_wen !== 1'b1) begin
            n_err++; $display("FAIL sh_bus: wdata=%h mask=%b wen=%b want abcdabcd 1100 1", ob_wdata, ob_wmask, ob_wen);
        end
        n_vec++;
        if (ob_lat !== 4 || ob_err !== 1'b0 || ob_memr !== model_memr) begin
            n_err++; $display("FAIL sh_done: lat=%0d err=%b mem_r=%h want 4 0 %h", ob_lat, ob_err, ob_memr, model_memr);
        end
    endtask

    task automatic test_misaligned;
        run_txn(1'b1, 2'd2, 1'b0, 32'h8000_0001, 32'h1234_5678, 32'h0, 0, 1);
        n_vec++;
        if (ob_lat !== 1 || ob_err !== 1'b1 || ob_req_seen !== 1'b0) begin
            n_err++; $display("FAIL sw_misaligned: lat=%0d err=%b req_seen=%b want 1 1 0", ob_lat, ob_err, ob_req_seen);
        end
        run_txn(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 1);
        n_vec++;
        if (ob_lat !== 1 || ob_err !== 1'b1 || ob_req_seen !== 1'b0 || ob_memr !== model_memr) begin
            n_err++; $display("FAIL illegal_size: lat=%0d err=%b req_seen=%b mem_r=%h", ob_lat, ob_err, ob_req_seen, ob_memr);
        end
    endtask

    task automatic test_backpressure;
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 5);
        model_memr = 32'hCAFE_F00D;
        n_vec++;
        if (ob_unstable !== 1'b0 || ob_hs_cnt !== 1 || ob_hs_lat !== 4) begin
            n_err++; $display("FAIL stall_req: unstable=%b hs=%0d hs_lat=%0d want 0 1 4", ob_unstable, ob_hs_cnt, ob_hs_lat);
        end
        n_vec++;
        if (ob_lat !== 10 || ob_extra !== 0 || ob_memr !== 32'hCAFE_F00D || ob_rdy_after !== 1'b1) begin
            n_err++; $display("FAIL stall_done: lat=%0d extra=%0d mem_r=%h rdy=%b want 10 0 cafef00d 1",
                              ob_lat, ob_extra, ob_memr, ob_rdy_after);
        end
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 0, 0);
        n_vec++;
        if (ob_lat !== MW + 2 || ob_err !== 1'b1 || ob_memr !== model_memr) begin
            n_err++; $display("FAIL timeout: lat=%0d err=%b mem_r=%h want %0d 1 %h", ob_lat, ob_err, ob_memr, MW + 2, model_memr);
        end
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 32'h5555_AAAA, 0, MW);
        model_memr = 32'h5555_AAAA;
        n_vec++;
        if (ob_lat !== MW + 2 || ob_err !== 1'b0 || ob_memr !== 32'h5555_AAAA) begin
            n_err++; $display("FAIL last_cycle_resp: lat=%0d err=%b mem_r=%h want %0d 0 5555aaaa", ob_lat, ob_err, ob_memr, MW + 2);
        end
    endtask

    task automatic test_reset_mid;
        int n_bad;
        n_bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; addr = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0; dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_vec++;
        if ({req_ready, done, err, dmem_req_valid, dmem_wen, dmem_wmask, mem_r} !== {1'b1, 40'h0}) begin
            n_err++;
            $display("FAIL reset_mid: rdy=%b done=%b err=%b rv=%b wen=%b mask=%h mem_r=%h want rdy=1 rest 0",
                     req_ready, done, err, dmem_req_valid, dmem_wen, dmem_wmask, mem_r);
        end
        dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h7777_7777;
        repeat (3) begin
            @(negedge clk);
            if (done || dmem_req_valid || mem_r !== 32'h0) n_bad++;
        end
        dmem_resp_valid = 1'b0;
        model_memr = 32'h0;
        n_vec++;
        if (n_bad !== 0) begin n_err++; $display("FAIL late_resp: reactions=%0d want 0", n_bad); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            logic        st, un;
            logic [1:0]  sz;
            logic [31:0] a, wd, rd;
            int          rdy, rk, exp_lat;
            bit          bad;
            st = $urandom; un = $urandom; sz = 2'($urandom_range(0, 3));
            a = $urandom; wd = $urandom; rd = $urandom;
            rdy = $urandom_range(0, 3);
            rk = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            bad = is_bad(sz, a[1:0]);
            run_txn(st, sz, un, a, wd, rd, rdy, rk);
            exp_lat = bad ? 1 : (rk == 0) ? (2 + rdy + MW) : (2 + rdy + rk);
            if (!bad && rk != 0 && !st) model_memr = ref_load(rd, a[1:0], sz, un);
            n_vec++;
            if (ob_lat !== exp_lat || ob_err !== (bad || rk == 0)) begin
                n_err++; $display("FAIL rnd_done[%0d]: lat=%0d err=%b want %0d %b", t, ob_lat, ob_err, exp_lat, bad || rk == 0);
            end
            n_vec++;
            if (ob_memr !== model_memr) begin
                n_err++; $display("FAIL rnd_mem_r[%0d]: got %h want %h", t, ob_memr, model_memr);
            end
            n_vec++;
            if (ob_req_seen !== !bad || ob_unstable !== 1'b0 || ob_extra !== 0) begin
                n_err++; $display("FAIL rnd_proto[%0d]: seen=%b unstable=%b extra=%0d want %b 0 0", t, ob_req_seen, ob_unstable, ob_extra, !bad);
            end
            if (!bad) begin
                n_vec++;
                if (ob_addr !== {a[31:2], 2'b00} || ob_wen !== st ||
                    ob_wmask !== (st ? ref_wmask(sz, a[1:0]) : 4'h0) ||
                    (st && ob_wdata !== ref_wdata(wd, sz))) begin
                    n_err++; $display("FAIL rnd_bus[%0d]: addr=%h wen=%b mask=%b wdata=%h want %h %b %b %h", t,
                                      ob_addr, ob_wen, ob_wmask, ob_wdata, {a[31:2], 2'b00}, st,
                                      st ? ref_wmask(sz, a[1:0]) : 4'h0, ref_wdata(wd, sz));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
